iob_ram_responder: RTL and testbench
====================================

Name: iob_ram_responder

Overview:
- IOb native bus responder (slave end) backed by a word-addressed synchronous RAM.
- Serves the same req/resp handshake the CPU-side initiators drive on ibus/dbus: avalid/addr/wdata/wstrb in, ready/rvalid/rdata out.
- Adds configurable wait states and read latency. Used as boot/scratch memory and as a timing-realistic bus model for CPU-level simulation.

Parameters:
- DATA_W, 32: data width, fixed at 32; wstrb is DATA_W/8.
- ADDR_W, 32: bus byte-address width.
- MEM_ADDR_W, 10: RAM word-address bits (1024 words).
- WAIT_STATES, 0: cycles avalid must be held before ready is asserted (0..15).
- LATENCY, 1: clock edges from read acceptance to the rvalid cycle (1..16).
- HEXFILE, "none": $readmemh init file; "none" leaves the RAM uninitialised.

Ports:
- clk_i  in  1  clock
- arst_n_i  in  1  asynchronous reset, active-low
- iob_avalid_i  in  1  request valid
- iob_addr_i  in  ADDR_W  byte address
- iob_wdata_i  in  DATA_W  write data
- iob_wstrb_i  in  DATA_W/8  byte strobes; nonzero means write, zero means read
- iob_ready_o  out  1  request accepted this cycle
- iob_rvalid_o  out  1  read data valid, single-cycle pulse
- iob_rdata_o  out  DATA_W  read data

Behaviour:
- One clock (clk_i). Reset is asynchronous, active-low (arst_n_i).
- Reset values: iob_ready_o=0, iob_rvalid_o=0, iob_rdata_o=0, state=IDLE, wait counter=0, latency counter=0. RAM contents are not reset.
- Word index is iob_addr_i[MEM_ADDR_W+1:2]. Upper address bits and addr[1:0] are ignored, so out-of-range addresses alias (wrap).
- States: IDLE, RD_WAIT.
- IDLE, wait counter wcnt:
  - wcnt clears whenever iob_avalid_i=0.
  - Increments while iob_avalid_i=1 and wcnt<WAIT_STATES.
  - iob_ready_o = iob_avalid_i & (state==IDLE) & (wcnt==WAIT_STATES). This is combinational from avalid and registered state.
  - With WAIT_STATES=0, ready is asserted in the same cycle as avalid.
- Acceptance means iob_avalid_i & iob_ready_o at a rising edge.
- Write acceptance (wstrb!=0):
  - Byte lanes with wstrb[i]=1 are written at that edge; other lanes are unchanged.
  - wcnt clears; state stays IDLE; no rvalid is generated.
  - A new request may be accepted on the very next cycle.
- Read acceptance (wstrb==0):
  - Go to RD_WAIT and load lcnt=LATENCY-1.
  - The RAM word is captured at the acceptance edge (read-before-any-later-write).
- RD_WAIT:
  - iob_ready_o=0. An initiator holding avalid on the same request must not cause a second acceptance.
  - lcnt decrements each edge.
  - When lcnt==0: iob_rvalid_o=1 for exactly one cycle, with iob_rdata_o = captured word. Next state is IDLE with wcnt=0.
  - Net timing: rvalid is high in cycle N+LATENCY, where N is the acceptance cycle.
- iob_rdata_o holds its last read value until the next rvalid. It is not zeroed after the pulse.
- Only one read is outstanding at a time. ready is never asserted in the rvalid cycle.
- Reset asserted mid-operation: the pending read is dropped, no rvalid is issued, state returns to IDLE, and RAM is unchanged.
- avalid deasserted during wait states: wcnt clears, and the request is treated as withdrawn (no side effect).

Optional Feature:
- Macro IOB_RAM_RESPONDER_STATS_EN.
- When defined:
  - Adds outputs rd_cnt_o[31:0] and wr_cnt_o[31:0].
  - Each increments by 1 on every read/write acceptance respectively, wrapping at 2^32.
  - Both reset to 0 on arst_n_i.
- When undefined: the ports and counters are absent, and behaviour is otherwise identical.

Test Plan:
- WAIT_STATES=0, LATENCY=1: write 0xDEADBEEF to addr 0x10 with wstrb=0xF, then read 0x10 -> ready in same cycle as avalid; rvalid one cycle after read acceptance with rdata=0xDEADBEEF.
- Byte strobe: write 0x11223344 to 0x20, then write 0xAABBCCDD with wstrb=0x5, then read -> rdata=0x11BB33DD.
- WAIT_STATES=3, LATENCY=4: hold avalid on read of 0x20 -> ready high in 4th avalid cycle only, ready low while avalid is held in RD_WAIT, rvalid exactly 4 cycles after acceptance, one pulse.
- Alias: MEM_ADDR_W=10, write 0x5A5A5A5A to 0x0000_0004, read 0x0000_1004 -> rdata=0x5A5A5A5A.
- Reset mid-read: LATENCY=4, read accepted, arst_n_i low 2 cycles later -> rvalid never pulses, outputs zero, and the following read of the same address returns the prior data.
- STATS_EN: 3 writes + 2 reads back-to-back -> wr_cnt_o=3, rd_cnt_o=2; after reset both 0.

Source files
------------

// File: rtl/iob_ram_responder.sv
// IOb native-bus responder backed by a word-addressed RAM, with configurable wait states and read latency.
// Defining IOB_RAM_RESPONDER_STATS_EN adds read/write acceptance counters rd_cnt_o / wr_cnt_o.
module iob_ram_responder #(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 32,
  parameter int MEM_ADDR_W  = 10,
  parameter int WAIT_STATES = 0,
  parameter int LATENCY     = 1,
  parameter     HEXFILE     = "none"
) (
  input  logic                clk_i,
  input  logic                arst_n_i,
  input  logic                iob_avalid_i,
  input  logic [ADDR_W-1:0]   iob_addr_i,
  input  logic [DATA_W-1:0]   iob_wdata_i,
  input  logic [DATA_W/8-1:0] iob_wstrb_i,
  output logic                iob_ready_o,
  output logic                iob_rvalid_o,
  output logic [DATA_W-1:0]   iob_rdata_o
`ifdef IOB_RAM_RESPONDER_STATS_EN
  ,
  output logic [31:0]         rd_cnt_o,
  output logic [31:0]         wr_cnt_o
`endif
);

  localparam logic [3:0] WS     = 4'(WAIT_STATES);
  localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

  typedef enum logic {IDLE, RD_WAIT} state_t;

  state_t                  r_state, w_state_nxt;
  logic [3:0]              r_wcnt, w_wcnt_nxt;
  logic [3:0]              r_lcnt, w_lcnt_nxt;
  logic                    w_ready, w_rvalid, w_rd_acc, w_wr_acc;
  logic [MEM_ADDR_W-1:0]   w_idx;
  logic [DATA_W-1:0]       r_mem [0:(1<<MEM_ADDR_W)-1];
  logic [DATA_W-1:0]       r_word;
  logic [DATA_W-1:0]       r_last;
  logic                    w_unused;

  // Upper address bits and the byte offset are ignored, so addresses alias.
  assign w_idx    = iob_addr_i[MEM_ADDR_W+1:2];
  assign w_unused = ^{iob_addr_i[ADDR_W-1:MEM_ADDR_W+2], iob_addr_i[1:0]};

  assign w_wr_acc = w_ready & (|iob_wstrb_i);
  assign w_rd_acc = w_ready & ~(|iob_wstrb_i);

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      r_state <= IDLE;
      r_wcnt  <= '0;
      r_lcnt  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_wcnt  <= w_wcnt_nxt;
      r_lcnt  <= w_lcnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_wcnt_nxt  = r_wcnt;
    w_lcnt_nxt  = r_lcnt;
    w_ready     = 1'b0;
    w_rvalid    = 1'b0;
    case (r_state)
      IDLE: begin
        w_ready = iob_avalid_i & (r_wcnt == WS);
        if (!iob_avalid_i) begin
          w_wcnt_nxt = '0;
        end else if (w_ready) begin
          w_wcnt_nxt = '0;
          if (iob_wstrb_i == '0) begin
            w_state_nxt = RD_WAIT;
            w_lcnt_nxt  = LAT_M1;
          end
        end else if (r_wcnt < WS) begin
          w_wcnt_nxt = r_wcnt + 4'd1;
        end
      end
      RD_WAIT: begin
        w_wcnt_nxt = '0;
        if (r_lcnt == '0) begin
          w_rvalid    = 1'b1;
          w_state_nxt = IDLE;
        end else begin
          w_lcnt_nxt = r_lcnt - 4'd1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // RAM array carries no reset so it survives arst_n_i.
  always_ff @(posedge clk_i) begin
    if (w_wr_acc) begin
      for (int i = 0; i < DATA_W/8; i++) begin
        if (iob_wstrb_i[i]) r_mem[w_idx][i*8 +: 8] <= iob_wdata_i[i*8 +: 8];
      end
    end
  end

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      r_word <= '0;
      r_last <= '0;
    end else begin
      if (w_rd_acc) r_word <= r_mem[w_idx];
      if (w_rvalid) r_last <= r_word;
    end
  end

  assign iob_ready_o  = w_ready;
  assign iob_rvalid_o = w_rvalid;
  // Captured word is shown in the rvalid cycle, then held until the next pulse.
  assign iob_rdata_o  = w_rvalid ? r_word : r_last;

`ifdef IOB_RAM_RESPONDER_STATS_EN
  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      rd_cnt_o <= '0;
      wr_cnt_o <= '0;
    end else begin
      if (w_rd_acc) rd_cnt_o <= rd_cnt_o + 32'd1;
      if (w_wr_acc) wr_cnt_o <= wr_cnt_o + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_iob_ram_responder.sv
// Bench for iob_ram_responder: two instances (0 wait/1 latency, 3 wait/4 latency) driven by
// random and directed requests, checked by a scoreboard against a word-array memory model.
module tb_iob_ram_responder;

  localparam int WS0 = 0, LAT0 = 1, WS1 = 3, LAT1 = 4;

  typedef struct packed {
    int          due;
    logic [31:0] d;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        avalid [2];
  logic [31:0] addr   [2];
  logic [31:0] wdata  [2];
  logic [3:0]  wstrb  [2];
  logic        ready  [2];
  logic        rvalid [2];
  logic [31:0] rdata  [2];

  int          vectors = 0;
  int          errs = 0;
  int          cyc = 0;
  exp_t        q0[$];
  exp_t        q1[$];
  logic [31:0] ref_mem [2][1024];
  logic [31:0] last_rd [2];
  logic [31:0] cnt_rd  [2];
  logic [31:0] cnt_wr  [2];

`ifdef IOB_RAM_RESPONDER_STATS_EN
  logic [31:0] rd_cnt [2];
  logic [31:0] wr_cnt [2];
`endif

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  iob_ram_responder #(.WAIT_STATES(WS0), .LATENCY(LAT0)) u_dut0 (
    .clk_i(clk), .arst_n_i(rst_n), .iob_avalid_i(avalid[0]), .iob_addr_i(addr[0]),
    .iob_wdata_i(wdata[0]), .iob_wstrb_i(wstrb[0]), .iob_ready_o(ready[0]),
    .iob_rvalid_o(rvalid[0]), .iob_rdata_o(rdata[0])
`ifdef IOB_RAM_RESPONDER_STATS_EN
    , .rd_cnt_o(rd_cnt[0]), .wr_cnt_o(wr_cnt[0])
`endif
  );

  iob_ram_responder #(.WAIT_STATES(WS1), .LATENCY(LAT1)) u_dut1 (
    .clk_i(clk), .arst_n_i(rst_n), .iob_avalid_i(avalid[1]), .iob_addr_i(addr[1]),
    .iob_wdata_i(wdata[1]), .iob_wstrb_i(wstrb[1]), .iob_ready_o(ready[1]),
    .iob_rvalid_o(rvalid[1]), .iob_rdata_o(rdata[1])
`ifdef IOB_RAM_RESPONDER_STATS_EN
    , .rd_cnt_o(rd_cnt[1]), .wr_cnt_o(wr_cnt[1])
`endif
  );

  function automatic int ws_of(int k);
    return (k == 0) ? WS0 : WS1;
  endfunction

  function automatic int lat_of(int k);
    return (k == 0) ? LAT0 : LAT1;
  endfunction

  function automatic void chk(string name, int k, logic [31:0] got, logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s dut%0d cyc=%0d: got %h expected %h", name, k, cyc, got, exp);
    end
  endfunction

  function automatic int qsize(int k);
    return (k == 0) ? q0.size() : q1.size();
  endfunction

  function automatic void push_exp(int k, exp_t e);
    if (k == 0) q0.push_back(e);
    else        q1.push_back(e);
  endfunction

  function automatic exp_t pop_exp(int k);
    return (k == 0) ? q0.pop_front() : q1.pop_front();
  endfunction

  function automatic bit overdue(int k);
    if (k == 0) return q0.size() > 0 && q0[0].due < cyc;
    return q1.size() > 0 && q1[0].due < cyc;
  endfunction

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        if (!rst_n) begin
          last_rd[k] = '0;
          continue;
        end
        if (rvalid[k]) begin
          chk("ready_in_rvalid_cycle", k, 32'(ready[k]), 32'd0);
          if (qsize(k) == 0) begin
            chk("spurious_rvalid", k, 32'(rvalid[k]), 32'd0);
          end else begin
            e = pop_exp(k);
            chk("rdata", k, rdata[k], e.d);
            chk("rvalid_cycle", k, cyc, e.due);
            last_rd[k] = e.d;
          end
        end else begin
          chk("rdata_hold", k, rdata[k], last_rd[k]);
          if (overdue(k)) begin
            chk("missing_rvalid", k, 32'(rvalid[k]), 32'd1);
            e = pop_exp(k);
          end
        end
      end
    end
  endtask

  // Issue one request starting just after a rising edge. extra = hold cycles for reads, gap for writes.
  task automatic do_req(int k, bit wr, logic [31:0] a, logic [31:0] d, logic [3:0] s, int extra);
    bit          acc;
    logic [31:0] w;
    exp_t        e;
    avalid[k] = 1'b1;
    addr[k]   = a;
    wdata[k]  = d;
    wstrb[k]  = wr ? s : 4'h0;
    acc = 1'b0;
    for (int n = 0; n <= ws_of(k); n++) begin
      @(negedge clk);
      chk("ready_timing", k, 32'(ready[k]), 32'(n == ws_of(k)));
      if (ready[k]) begin
        acc = 1'b1;
        break;
      end
    end
    if (!acc) begin
      @(posedge clk); #1;
      avalid[k] = 1'b0;
      return;
    end
    if (wr) begin
      w = ref_mem[k][a[11:2]];
      for (int b = 0; b < 4; b++) if (s[b]) w[8*b +: 8] = d[8*b +: 8];
      ref_mem[k][a[11:2]] = w;
      cnt_wr[k]++;
    end else begin
      e.due = cyc + lat_of(k);
      e.d   = ref_mem[k][a[11:2]];
      push_exp(k, e);
      cnt_rd[k]++;
    end
    @(posedge clk); #1;
    if (wr) begin
      if (extra > 0) begin
        avalid[k] = 1'b0;
        repeat (extra) begin @(posedge clk); #1; end
      end
    end else begin
      for (int h = 0; h < extra; h++) begin
        @(negedge clk);
        chk("ready_low_in_rd_wait", k, 32'(ready[k]), 32'd0);
        @(posedge clk); #1;
      end
      avalid[k] = 1'b0;
      for (int t = 0; t < 40 && qsize(k) != 0; t++) begin
        @(posedge clk); #1;
      end
      if (qsize(k) != 0) chk("rvalid_timeout", k, qsize(k), 32'd0);
    end
  endtask

  task automatic withdraw(int k, int n);
    avalid[k] = 1'b1;
    addr[k]   = {$urandom_range(0, 15), 2'b00};
    wdata[k]  = $urandom;
    wstrb[k]  = 4'hF;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk("ready_during_wait", k, 32'(ready[k]), 32'd0);
      @(posedge clk); #1;
    end
    avalid[k] = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic idle(int k);
    avalid[k] = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic check_zero_outputs(string tag);
    for (int k = 0; k < 2; k++) begin
      chk({tag, "_ready"}, k, 32'(ready[k]), 32'd0);
      chk({tag, "_rvalid"}, k, 32'(rvalid[k]), 32'd0);
      chk({tag, "_rdata"}, k, rdata[k], 32'd0);
    end
  endtask

  task automatic check_stats();
`ifdef IOB_RAM_RESPONDER_STATS_EN
    for (int k = 0; k < 2; k++) begin
      chk("rd_cnt", k, rd_cnt[k], cnt_rd[k]);
      chk("wr_cnt", k, wr_cnt[k], cnt_wr[k]);
    end
`endif
  endtask

  initial begin
    logic [31:0] tmp;
    logic [9:0]  idx;
    bit          acc;
    int          r;
    for (int k = 0; k < 2; k++) begin
      avalid[k] = 1'b0; addr[k] = '0; wdata[k] = '0; wstrb[k] = '0;
      last_rd[k] = '0; cnt_rd[k] = '0; cnt_wr[k] = '0;
    end
    fork monitor(); join_none

    repeat (3) @(posedge clk);
    @(negedge clk);
    check_zero_outputs("reset");
    check_stats();
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed: full write/read, byte strobes, aliasing; then held read on the slow instance.
    for (int k = 0; k < 2; k++) begin
      do_req(k, 1, 32'h10, 32'hDEADBEEF, 4'hF, 1);
      do_req(k, 0, 32'h10, 32'h0, 4'h0, 0);
      do_req(k, 1, 32'h20, 32'h11223344, 4'hF, 0);
      do_req(k, 1, 32'h20, 32'hAABBCCDD, 4'h5, 1);
      do_req(k, 0, 32'h20, 32'h0, 4'h0, lat_of(k));
      do_req(k, 1, 32'h4, 32'h5A5A5A5A, 4'hF, 1);
      do_req(k, 0, 32'h1004, 32'h0, 4'h0, 0);
      for (int i = 0; i < 16; i++) do_req(k, 1, 32'(i * 4), $urandom, 4'hF, 0);
      idle(k);
    end

    // Random traffic with aliased upper address bits and odd byte offsets.
    for (int k = 0; k < 2; k++) begin
      for (int it = 0; it < 120; it++) begin
        tmp = $urandom;
        idx = 10'($urandom_range(0, 15));
        r   = $urandom_range(0, 9);
        if (r < 4)
          do_req(k, 0, {tmp[31:12], idx, tmp[1:0]}, 32'h0, 4'h0, $urandom_range(0, lat_of(k)));
        else if (r < 8 || k == 0)
          do_req(k, 1, {tmp[31:12], idx, tmp[1:0]}, $urandom, 4'($urandom_range(1, 15)),
                 $urandom_range(0, 2));
        else
          withdraw(k, $urandom_range(1, ws_of(k)));
      end
      idle(k);
    end
    check_stats();

    // Reset two cycles after a read is accepted on the latency-4 instance.
    avalid[1] = 1'b1; addr[1] = 32'h20; wdata[1] = '0; wstrb[1] = 4'h0;
    acc = 1'b0;
    for (int n = 0; n <= WS1; n++) begin
      @(negedge clk);
      if (ready[1]) begin acc = 1'b1; break; end
    end
    chk("rst_read_accepted", 1, 32'(acc), 32'd1);
    @(posedge clk); #1;
    avalid[1] = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    q1.delete();
    for (int k = 0; k < 2; k++) begin cnt_rd[k] = '0; cnt_wr[k] = '0; end
    @(negedge clk);
    check_zero_outputs("mid_reset");
    repeat (2) @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (8) @(posedge clk); #1;
    check_stats();
    do_req(1, 0, 32'h20, 32'h0, 4'h0, 0);
    do_req(0, 0, 32'h20, 32'h0, 4'h0, 0);

    // Back-to-back writes then reads for the acceptance counters.
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 3; i++) do_req(k, 1, 32'(i * 4), $urandom, 4'hF, 0);
      do_req(k, 0, 32'h0, 32'h0, 4'h0, 0);
      do_req(k, 0, 32'h8, 32'h0, 4'h0, 0);
    end
    check_stats();

    repeat (4) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
